// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the decode/execute boundary of the
// 16-register pipelined core.
//   REG_PC         - register index that aliases the program counter
//   DEFAULT_CTRL_W - default width of the opaque ALU/memory control bundle
//   fwd_sel_t      - operand source select for the EX operand muxes
//   fwd_select()   - picks the operand source for one EX source register
// Used by id_ex_hazard_stage and hazard_detect. The FORWARD_EN macro decides
// whether fwd_select() ends up in hardware; the package itself is macro-free.
package pipeline_pkg;

  localparam logic [3:0] REG_PC         = 4'd15;
  localparam int         DEFAULT_CTRL_W = 8;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  // MEM beats WB because it holds the younger write; the PC alias is never
  // forwarded since its read value comes from the fetch side, not a writer.
  function automatic fwd_sel_t fwd_select(
    input logic [3:0] src,
    input logic [3:0] mem_rd,
    input logic       mem_we,
    input logic [3:0] wb_rd,
    input logic       wb_we
  );
    fwd_sel_t sel;
    if (src == REG_PC) begin
      sel = FWD_NONE;
    end else if (mem_we && (src == mem_rd)) begin
      sel = FWD_MEM;
    end else if (wb_we && (src == wb_rd)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
// hazard_detect: purely combinational hazard and stall generation.
// Macro: FORWARD_EN
//   defined   - only load-use hazards (live source == rd of a load in EX)
//   undefined - full RAW interlock against the EX and MEM producers
// Ports:
//   reset, flush_in              - both suppress the stall
//   id_valid, id_ra*, id_use*    - decode slot sources
//   ex_valid/ex_we/ex_load/ex_rd - instruction currently in EX
//   mem_we, mem_rd               - instruction currently in MEM
//   stall                        - hold PC and IF/ID, insert a bubble
// WB never needs a check: the register file writes on the falling edge, so
// the decode read already returns the WB value.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       reset,
  input  logic       flush_in,
  input  logic       id_valid,
  input  logic [3:0] id_ra0,
  input  logic       id_use0,
  input  logic [3:0] id_ra1,
  input  logic       id_use1,
  input  logic       ex_valid,
  input  logic       ex_we,
  input  logic       ex_load,
  input  logic [3:0] ex_rd,
  input  logic       mem_we,
  input  logic [3:0] mem_rd,
  output logic       stall
);

  logic live0_s;
  logic live1_s;
  logic hazard_s;

  assign live0_s = id_valid & id_use0 & (id_ra0 != REG_PC);
  assign live1_s = id_valid & id_use1 & (id_ra1 != REG_PC);

`ifdef FORWARD_EN
  // Everything except a load result can be forwarded, so only a load sitting
  // in EX forces the consumer to wait one cycle.
  logic ex_load_hit_s;
  logic unused_mem_s;

  assign ex_load_hit_s = ex_valid & ex_we & ex_load;
  assign hazard_s      = ex_load_hit_s &
                         ((live0_s & (id_ra0 == ex_rd)) |
                          (live1_s & (id_ra1 == ex_rd)));
  assign unused_mem_s  = ^{mem_we, mem_rd};
`else
  // With no bypass network any in-flight writer in EX or MEM blocks the read.
  logic ex_hit_s;
  logic unused_load_s;

  assign ex_hit_s      = ex_valid & ex_we;
  assign hazard_s      = (live0_s & ((ex_hit_s & (id_ra0 == ex_rd)) |
                                     (mem_we   & (id_ra0 == mem_rd)))) |
                         (live1_s & ((ex_hit_s & (id_ra1 == ex_rd)) |
                                     (mem_we   & (id_ra1 == mem_rd))));
  assign unused_load_s = ex_load;
`endif

  // A flush kills the decode slot anyway, so stalling it would only waste a cycle.
  assign stall = hazard_s & ~flush_in & ~reset;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with hazard interlock,
// optional MEM/WB operand forwarding and a saturating stall counter.
// Macro: FORWARD_EN (enables the MEM/WB forwarding muxes and relaxes the
//   interlock to load-use only; undefined gives a full RAW interlock).
// Ports:
//   clk, reset             - rising-edge clock, synchronous active-high reset
//   id_*                   - decode slot: sources, read data, dest, control
//   flush_in               - taken branch in EX, turn the decode slot into a bubble
//   mem_rd/we/result       - EX/MEM write info (valid-qualified)
//   wb_rd/we/result        - MEM/WB write info (valid-qualified)
//   stall                  - combinational hold for PC and IF/ID
//   ex_valid/we/load/rd/ctrl - registered control for EX
//   ex_op0, ex_op1         - EX operands (combinational from ID/EX + bypass)
//   stall_cycles           - saturating count of stall cycles
module id_ex_hazard_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [3:0]        id_ra0,
  input  logic [3:0]        id_ra1,
  input  logic              id_use0,
  input  logic              id_use1,
  input  logic [WIDTH-1:0]  id_data0,
  input  logic [WIDTH-1:0]  id_data1,
  input  logic [3:0]        id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush_in,
  input  logic [3:0]        mem_rd,
  input  logic              mem_we,
  input  logic [WIDTH-1:0]  mem_result,
  input  logic [3:0]        wb_rd,
  input  logic              wb_we,
  input  logic [WIDTH-1:0]  wb_result,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_we,
  output logic              ex_load,
  output logic [3:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [WIDTH-1:0]  ex_op0,
  output logic [WIDTH-1:0]  ex_op1,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_we_q,    ex_we_d;
  logic              ex_load_q,  ex_load_d;
  logic [3:0]        ex_rd_q,    ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [3:0]        ex_ra0_q,   ex_ra0_d;
  logic [3:0]        ex_ra1_q,   ex_ra1_d;
  logic [WIDTH-1:0]  ex_data0_q, ex_data0_d;
  logic [WIDTH-1:0]  ex_data1_q, ex_data1_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic              stall_s;

  hazard_detect u_hazard_detect (
    .reset    (reset),
    .flush_in (flush_in),
    .id_valid (id_valid),
    .id_ra0   (id_ra0),
    .id_use0  (id_use0),
    .id_ra1   (id_ra1),
    .id_use1  (id_use1),
    .ex_valid (ex_valid_q),
    .ex_we    (ex_we_q),
    .ex_load  (ex_load_q),
    .ex_rd    (ex_rd_q),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .stall    (stall_s)
  );

  // ID/EX next state: flush bubble, else stall bubble, else capture decode.
  // Operand data and source indices are left alone under a bubble; nothing
  // consumes them while ex_valid is low.
  always_comb begin
    ex_ra0_d   = ex_ra0_q;
    ex_ra1_d   = ex_ra1_q;
    ex_data0_d = ex_data0_q;
    ex_data1_d = ex_data1_q;
    if (flush_in || stall_s) begin
      ex_valid_d = 1'b0;
      ex_we_d    = 1'b0;
      ex_load_d  = 1'b0;
      ex_rd_d    = 4'd0;
      ex_ctrl_d  = {CTRL_W{1'b0}};
    end else begin
      ex_valid_d = id_valid;
      ex_we_d    = id_we;
      ex_load_d  = id_load;
      ex_rd_d    = id_rd;
      ex_ctrl_d  = id_ctrl;
      ex_ra0_d   = id_ra0;
      ex_ra1_d   = id_ra1;
      ex_data0_d = id_data0;
      ex_data1_d = id_data1;
    end
  end

  // Stall counter next state: count stalled cycles, stick at all-ones.
  always_comb begin
    if (stall_s && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // ID/EX and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_we_q        <= 1'b0;
      ex_load_q      <= 1'b0;
      ex_rd_q        <= 4'd0;
      ex_ctrl_q      <= {CTRL_W{1'b0}};
      ex_ra0_q       <= 4'd0;
      ex_ra1_q       <= 4'd0;
      ex_data0_q     <= {WIDTH{1'b0}};
      ex_data1_q     <= {WIDTH{1'b0}};
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_we_q        <= ex_we_d;
      ex_load_q      <= ex_load_d;
      ex_rd_q        <= ex_rd_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_ra0_q       <= ex_ra0_d;
      ex_ra1_q       <= ex_ra1_d;
      ex_data0_q     <= ex_data0_d;
      ex_data1_q     <= ex_data1_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

`ifdef FORWARD_EN
  fwd_sel_t fwd_sel0_s;
  fwd_sel_t fwd_sel1_s;

  assign fwd_sel0_s = fwd_select(ex_ra0_q, mem_rd, mem_we, wb_rd, wb_we);
  assign fwd_sel1_s = fwd_select(ex_ra1_q, mem_rd, mem_we, wb_rd, wb_we);

  // Operand 0 bypass mux.
  always_comb begin
    case (fwd_sel0_s)
      FWD_MEM: ex_op0 = mem_result;
      FWD_WB:  ex_op0 = wb_result;
      default: ex_op0 = ex_data0_q;
    endcase
  end

  // Operand 1 bypass mux.
  always_comb begin
    case (fwd_sel1_s)
      FWD_MEM: ex_op1 = mem_result;
      FWD_WB:  ex_op1 = wb_result;
      default: ex_op1 = ex_data1_q;
    endcase
  end
`else
  logic unused_fwd_s;

  // The interlock keeps every consumer until its producer has reached the
  // register file, so the captured read data is always current.
  assign ex_op0       = ex_data0_q;
  assign ex_op1       = ex_data1_q;
  assign unused_fwd_s = ^{mem_result, wb_rd, wb_we, wb_result, ex_ra0_q, ex_ra1_q};
`endif

  assign stall        = stall_s;
  assign ex_valid     = ex_valid_q;
  assign ex_we        = ex_we_q;
  assign ex_load      = ex_load_q;
  assign ex_rd        = ex_rd_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage. The driver sets inputs shortly
// after each rising edge and pushes the hand-computed response expected at
// the following falling edge; a monitor pops and compares on every falling
// edge. Expectations follow the FORWARD_EN setting of the build.
module tb_id_ex_hazard_stage;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 2;

`ifdef FORWARD_EN
  localparam logic        NF      = 1'b0;
  localparam logic [31:0] OP_DUAL = 32'h0000_0001;
`else
  localparam logic        NF      = 1'b1;
  localparam logic [31:0] OP_DUAL = 32'h0000_0077;
`endif

  logic              clk;
  logic              reset;
  logic              id_valid;
  logic [3:0]        id_ra0, id_ra1;
  logic              id_use0, id_use1;
  logic [WIDTH-1:0]  id_data0, id_data1;
  logic [3:0]        id_rd;
  logic              id_we, id_load;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush_in;
  logic [3:0]        mem_rd, wb_rd;
  logic              mem_we, wb_we;
  logic [WIDTH-1:0]  mem_result, wb_result;
  logic              stall;
  logic              ex_valid, ex_we, ex_load;
  logic [3:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [WIDTH-1:0]  ex_op0, ex_op1;
  logic [CNT_W-1:0]  stall_cycles;

  id_ex_hazard_stage #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ra0(id_ra0), .id_ra1(id_ra1),
    .id_use0(id_use0), .id_use1(id_use1),
    .id_data0(id_data0), .id_data1(id_data1),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .id_ctrl(id_ctrl),
    .flush_in(flush_in),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_result(wb_result),
    .stall(stall), .ex_valid(ex_valid), .ex_we(ex_we), .ex_load(ex_load),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_op0(ex_op0), .ex_op1(ex_op1),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] tag;
    logic        st;
    logic        v;
    logic        we;
    logic        ld;
    logic [3:0]  rd;
    logic [7:0]  ctrl;
    logic        c0;
    logic [31:0] o0;
    logic        c1;
    logic [31:0] o1;
    logic [1:0]  cnt;
  } exp_t;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] exp_cnt = 2'd0;

  task automatic chk(input logic [95:0] tag, input string f,
                     input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_bad++;
      $display("FAIL %0s %0s actual=%0h required=%0h", tag, f, act, req);
    end
  endtask

  // Monitor: compare each falling-edge snapshot against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      chk(e.tag, "stall",        {31'd0, stall},    {31'd0, e.st});
      chk(e.tag, "ex_valid",     {31'd0, ex_valid}, {31'd0, e.v});
      chk(e.tag, "ex_we",        {31'd0, ex_we},    {31'd0, e.we});
      chk(e.tag, "ex_load",      {31'd0, ex_load},  {31'd0, e.ld});
      chk(e.tag, "ex_rd",        {28'd0, ex_rd},    {28'd0, e.rd});
      chk(e.tag, "ex_ctrl",      {24'd0, ex_ctrl},  {24'd0, e.ctrl});
      chk(e.tag, "stall_cycles", {30'd0, stall_cycles}, {30'd0, e.cnt});
      if (e.c0) chk(e.tag, "ex_op0", ex_op0, e.o0);
      if (e.c1) chk(e.tag, "ex_op1", ex_op1, e.o1);
    end
  end

  task automatic set_id(input logic v, input logic [3:0] ra0, input logic u0,
                        input logic [31:0] d0, input logic [3:0] ra1,
                        input logic u1, input logic [31:0] d1,
                        input logic [3:0] rd, input logic we, input logic ld,
                        input logic [7:0] ctrl);
    id_valid = v;  id_ra0 = ra0; id_use0 = u0; id_data0 = d0;
    id_ra1 = ra1;  id_use1 = u1; id_data1 = d1;
    id_rd = rd;    id_we = we;   id_load = ld; id_ctrl = ctrl;
  endtask

  task automatic idle_id();
    set_id(1'b0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic set_mw(input logic [3:0] mrd, input logic mwe, input logic [31:0] mres,
                        input logic [3:0] wrd, input logic wwe, input logic [31:0] wres);
    mem_rd = mrd; mem_we = mwe; mem_result = mres;
    wb_rd  = wrd; wb_we  = wwe; wb_result  = wres;
  endtask

  // Push the expectation for this cycle, track the counter, advance one cycle.
  task automatic cyc(input logic [95:0] tag, input logic st, input logic v,
                     input logic we, input logic ld, input logic [3:0] rd,
                     input logic [7:0] ctrl, input logic c0, input logic [31:0] o0,
                     input logic c1, input logic [31:0] o1);
    exp_t e;
    e.tag = tag; e.st = st; e.v = v; e.we = we; e.ld = ld; e.rd = rd;
    e.ctrl = ctrl; e.c0 = c0; e.o0 = o0; e.c1 = c1; e.o1 = o1; e.cnt = exp_cnt;
    q.push_back(e);
    if (reset) exp_cnt = 2'd0;
    else if (st && (exp_cnt != 2'd3)) exp_cnt = exp_cnt + 2'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic bub(input logic [95:0] tag, input logic st, input logic c0,
                     input logic [31:0] o0, input logic c1, input logic [31:0] o1);
    cyc(tag, st, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, c0, o0, c1, o1);
  endtask

  initial begin
    reset = 1'b1;
    flush_in = 1'b0;
    idle_id();
    set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    bub("rst", 1'b0, 1'b1, 32'd0, 1'b1, 32'd0);
    reset = 1'b0;
    bub("idle", 1'b0, 1'b1, 32'd0, 1'b1, 32'd0);

    // Back-to-back dependent ALU ops on r3
    set_id(1'b1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd3, 1'b1, 1'b0, 8'h11);
    bub("s1_a", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    set_id(1'b1, 4'd3, 1'b1, 32'hDEAD_0003, 4'd0, 1'b0, 32'd0, 4'd4, 1'b1, 1'b0, 8'h22);
    cyc("s1_b", NF, 1'b1, 1'b1, 1'b0, 4'd3, 8'h11, 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef FORWARD_EN
    idle_id();
    set_mw(4'd3, 1'b1, 32'h10, 4'd0, 1'b0, 32'd0);
    cyc("s1_c", 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 8'h22, 1'b1, 32'h10, 1'b0, 32'd0);
    set_mw(4'd0, 1'b0, 32'd0, 4'd3, 1'b1, 32'h10);
    bub("s1_d", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
`else
    set_mw(4'd3, 1'b1, 32'h10, 4'd0, 1'b0, 32'd0);
    bub("s1_c", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    set_id(1'b1, 4'd3, 1'b1, 32'h10, 4'd0, 1'b0, 32'd0, 4'd4, 1'b1, 1'b0, 8'h22);
    set_mw(4'd0, 1'b0, 32'd0, 4'd3, 1'b1, 32'h10);
    bub("s1_d", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle_id();
    set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    cyc("s1_e", 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 8'h22, 1'b1, 32'h10, 1'b0, 32'd0);
`endif

    // Load-use on r5
    set_id(1'b1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd5, 1'b1, 1'b1, 8'h33);
    set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    bub("s2_a", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    set_id(1'b1, 4'd0, 1'b0, 32'd0, 4'd5, 1'b1, 32'hBAD0_0005, 4'd6, 1'b1, 1'b0, 8'h44);
    cyc("s2_b", 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 8'h33, 1'b0, 32'd0, 1'b0, 32'd0);
    set_mw(4'd5, 1'b1, 32'h1234, 4'd0, 1'b0, 32'd0);
    bub("s2_c", NF, 1'b0, 32'd0, 1'b0, 32'd0);
`ifdef FORWARD_EN
    idle_id();
    set_mw(4'd0, 1'b0, 32'd0, 4'd5, 1'b1, 32'hABCD);
    cyc("s2_d", 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 8'h44, 1'b0, 32'd0, 1'b1, 32'hABCD);
`else
    set_id(1'b1, 4'd0, 1'b0, 32'd0, 4'd5, 1'b1, 32'hABCD, 4'd6, 1'b1, 1'b0, 8'h44);
    set_mw(4'd0, 1'b0, 32'd0, 4'd5, 1'b1, 32'hABCD);
    bub("s2_d", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle_id();
    set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    cyc("s2_e", 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 8'h44, 1'b0, 32'd0, 1'b1, 32'hABCD);
`endif

    // PC (r15) is neither a hazard source nor forwarded
    set_id(1'b1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd15, 1'b1, 1'b0, 8'h55);
    set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    bub("s3_a", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    set_id(1'b1, 4'd15, 1'b1, 32'h100, 4'd0, 1'b0, 32'd0, 4'd7, 1'b1, 1'b0, 8'h66);
    cyc("s3_b", 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 8'h55, 1'b0, 32'd0, 1'b0, 32'd0);
    idle_id();
    set_mw(4'd15, 1'b1, 32'hFFFF_FFFF, 4'd15, 1'b1, 32'hEEEE_EEEE);
    cyc("s3_c", 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 8'h66, 1'b1, 32'h100, 1'b0, 32'd0);

    // Dual MEM/WB match on r2: MEM wins
    set_id(1'b1, 4'd2, 1'b1, 32'h77, 4'd0, 1'b0, 32'h99, 4'd8, 1'b1, 1'b0, 8'h77);
    set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    bub("s4_a", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle_id();
    set_mw(4'd2, 1'b1, 32'd1, 4'd2, 1'b1, 32'd2);
    cyc("s4_b", 1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 8'h77, 1'b1, OP_DUAL, 1'b1, 32'h99);

    // Flush in the same cycle as a load-use hazard
    set_id(1'b1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd9, 1'b1, 1'b1, 8'h88);
    set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    bub("s5_a", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    set_id(1'b1, 4'd9, 1'b1, 32'd5, 4'd0, 1'b0, 32'd0, 4'd10, 1'b1, 1'b0, 8'h99);
    flush_in = 1'b1;
    cyc("s5_b", 1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 8'h88, 1'b0, 32'd0, 1'b0, 32'd0);
    flush_in = 1'b0;
    idle_id();
    set_mw(4'd9, 1'b1, 32'h4444, 4'd0, 1'b0, 32'd0);
    bub("s5_c", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // Counter saturation: clear, then five load-use stalls with CNT_W = 2
    reset = 1'b1;
    set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    bub("s6_rst", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd10, 1'b1, 1'b1, 8'hA0);
      set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
      bub("sat_p", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      set_id(1'b1, 4'd10, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd11, 1'b1, 1'b0, 8'hB0);
      cyc("sat_q", 1'b1, 1'b1, 1'b1, 1'b1, 4'd10, 8'hA0, 1'b0, 32'd0, 1'b0, 32'd0);
      idle_id();
      set_mw(4'd10, 1'b1, 32'd2, 4'd0, 1'b0, 32'd0);
      bub("sat_r", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    end

    // Reset asserted while a stall would be raised
    set_id(1'b1, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd10, 1'b1, 1'b1, 8'hA0);
    set_mw(4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    bub("rm_p", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    set_id(1'b1, 4'd10, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd11, 1'b1, 1'b0, 8'hB0);
    reset = 1'b1;
    cyc("rm_q", 1'b0, 1'b1, 1'b1, 1'b1, 4'd10, 8'hA0, 1'b0, 32'd0, 1'b0, 32'd0);
    reset = 1'b0;
    idle_id();
    bub("rm_done", 1'b0, 1'b1, 32'd0, 1'b1, 32'd0);

    for (int i = 0; (i < 10) && (q.size() > 0); i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d required=0 pending expectations", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_stage.md
# id_ex_hazard_stage

Decode-to-execute pipeline stage for the 16-register pipelined core. It sits directly downstream of the register file. It captures the two read-port values plus decode control into the ID/EX register. It detects RAW and load-use hazards, drives the fetch/decode stall and bubble insertion, and (optionally) forwards MEM/WB results onto the EX operands.

## Interface
Parameters:
- WIDTH, 32, datapath width
- CTRL_W, 8, opaque ALU/memory control bundle width
- CNT_W, 16, stall-cycle counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_ra0, id_ra1  in  4  source selects sent to the register file read ports
- id_use0, id_use1  in  1  source actually read by the instruction
- id_data0, id_data1  in  WIDTH  register-file read data (port 0/1; index 15 = PC value)
- id_rd  in  4  destination select
- id_we  in  1  instruction writes id_rd
- id_load  in  1  instruction is a load
- id_ctrl  in  CTRL_W  control bundle
- flush_in  in  1  taken branch resolved in EX; kill the decode slot
- mem_rd, mem_we, mem_result  in  4/1/WIDTH  EX/MEM stage write info (mem_we already valid-qualified)
- wb_rd, wb_we, wb_result  in  4/1/WIDTH  MEM/WB stage write info (mem_we/wb_we already valid-qualified)
- stall  out  1  hold PC and IF/ID register this cycle
- ex_valid, ex_we, ex_load  out  1  registered control
- ex_rd  out  4; ex_ctrl  out  CTRL_W
- ex_op0, ex_op1  out  WIDTH  EX operands (forwarded when enabled)
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Register 15 (PC) is never a hazard source and never forwarded; matches on index 15 are ignored.
- A source is "live" if id_valid & id_useN & id_raN != 15.
- With forwarding, the hazard is load-use: a live source equals ex_rd while ex_valid & ex_we & ex_load.
- Without forwarding, the hazard is any live source equal to ex_rd (ex_valid & ex_we) or to mem_rd (mem_we).
- WB needs no decode-side check: the register file writes on the falling edge, so the decode read already sees the WB value.
- stall = hazard & ~flush_in & ~reset (combinational).
- Priority of each ID/EX register update, highest first:
  - reset: all ex_* cleared to 0.
  - flush_in: bubble (ex_valid = ex_we = ex_load = 0, ex_rd = 0, ex_ctrl = 0).
  - stall: bubble is inserted and the decode inputs are not captured.
  - otherwise: capture all id_* inputs, including ra0/ra1, which are held internally.
- Forwarding on operand N:
  - if ex_raN == mem_rd & mem_we & ex_raN != 15, the operand is mem_result.
  - else if ex_raN == wb_rd & wb_we & ex_raN != 15, the operand is wb_result.
  - else the operand is the captured register data.
  - MEM has priority over WB.
  - A load in MEM is never consumed by forwarding, because the load-use stall guarantees it.
- stall_cycles increments on every cycle with stall = 1. It saturates at all-ones and clears on reset.

## Timing
- ID to EX latency is 1 cycle; ex_op0/ex_op1 are combinational from the registered data and the MEM/WB inputs.
- Reset values: ex_valid = ex_we = ex_load = 0, ex_rd = 0, ex_ctrl = 0, captured data = 0, stall_cycles = 0, stall = 0.
- A load-use stall lasts exactly 1 cycle.
- A non-forwarding stall lasts 1 or 2 cycles: 2 when the producer is in EX, 1 when it is in MEM.
- flush_in and stall in the same cycle: the flush wins, stall = 0, and the bubble is inserted.
- Reset asserted mid-stall: the next cycle has all outputs at their reset values and the counter does not increment.
- A bubble in EX (ex_valid = 0) never causes a hazard.

## Configuration
- FORWARD_EN defined:
  - MEM/WB forwarding muxes present.
  - Only load-use hazards stall.
- FORWARD_EN undefined:
  - No forwarding muxes; ex_opN = captured register data.
  - Full RAW interlock against the EX and MEM stages.

## Structure
- Shared package pipeline_pkg:
  - REG_PC = 4'd15
  - default CTRL_W
  - fwd_sel_t enum {FWD_NONE, FWD_MEM, FWD_WB}
- One sub-module, hazard_detect: purely combinational hazard/stall logic, macro-aware.
- The ID/EX registers, forwarding muxes and counter live in the top module.

## Test plan
- Back-to-back dependent ALU ops.
  - Stimulus: I1 writes r3 = 0x10; I2 reads r3.
  - FORWARD_EN: no stall; I2's ex_op0 = 0x10 via FWD_MEM.
  - Without FORWARD_EN: 2 stall cycles, then ex_op0 = 0x10 from the register file.
- Load-use.
  - Stimulus: I1 is a load to r5 (returns 0xABCD); I2 reads r5.
  - Required: stall = 1 for exactly 1 cycle; ex_valid = 0 bubble; then I2's ex_op1 = 0xABCD via FWD_WB.
- PC source.
  - Stimulus: I1 writes r15 while I2 reads r15.
  - Required: no stall and no forward; ex_op0 = the id_data0 PC value.
- Dual match.
  - Stimulus: mem_rd = wb_rd = r2 with mem_result = 1, wb_result = 2.
  - Required: ex_op0 = 1 (MEM priority).
- Flush during a stall.
  - Stimulus: load-use hazard and flush_in = 1 in the same cycle.
  - Required: stall = 0; next ex_valid = 0; stall_cycles unchanged.
- Counter saturation and reset.
  - Stimulus: CNT_W = 2 with 5 stall cycles.
  - Required: stall_cycles = 3.
  - Then assert reset: stall_cycles = 0 and all ex_* = 0 on the next edge.
